// File: rtl/ddr3_mcb_wdat_buf_if.sv
// rtl/ddr3_mcb_wdat_buf_if.sv - write-data buffer bus bundle
//
// Groups the AXI write-data beat handshake, the sequencer write command
// and the beat stream toward the DDR3 data FF stage.
//   master : upstream side (AXI source + command sequencer + FF-stage sink)
//   slave  : the write-data staging buffer
interface ddr3_mcb_wdat_buf_if #(
    parameter int BL_W = 4
);
    logic            axi_wvalid;
    logic            axi_wready;
    logic [63:0]     axi_wdata;
    logic [7:0]      axi_wstrb;

    logic            wr_req;
    logic [BL_W-1:0] wr_len;
    logic            wr_busy;
    logic            wr_done;

    logic            d_wr_ld;
    logic [63:0]     ddr3_mcb_wdat;
    logic [7:0]      ddr3_mcb_wbe;

    modport master (
        output axi_wvalid, axi_wdata, axi_wstrb, wr_req, wr_len,
        input  axi_wready, wr_busy, wr_done, d_wr_ld, ddr3_mcb_wdat, ddr3_mcb_wbe
    );

    modport slave (
        input  axi_wvalid, axi_wdata, axi_wstrb, wr_req, wr_len,
        output axi_wready, wr_busy, wr_done, d_wr_ld, ddr3_mcb_wdat, ddr3_mcb_wbe
    );
endinterface

// File: rtl/ddr3_mcb_wdat_buf.sv
// rtl/ddr3_mcb_wdat_buf.sv - DDR3 write-data staging FIFO and fixed-latency beat issuer
//
// Ports:
//   ddr3_mcb_clk : controller clock, rising edge
//   ddr3_mcb_rst : synchronous reset, active-high
//   bus          : slave side of ddr3_mcb_wdat_buf_if (AXI W beats in,
//                  wr_req/wr_len command in, wr_busy/wr_done status out,
//                  d_wr_ld/ddr3_mcb_wdat/ddr3_mcb_wbe beats out)
//   fifo_cnt     : current FIFO occupancy in beats
//   underrun     : sticky, a beat fell due while the FIFO was empty
module ddr3_mcb_wdat_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int BL_W  = 4,
    parameter int CWL   = 5
) (
    input  logic                 ddr3_mcb_clk,
    input  logic                 ddr3_mcb_rst,
    ddr3_mcb_wdat_buf_if.slave   bus,
    output logic [AW:0]          fifo_cnt,
    output logic                 underrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BL_W-1:0] len_cnt;
    logic [3:0]      lat_cnt;
    logic            take;
    logic            push;
    logic            pop;
    logic            fifo_empty;

    logic [71:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // beat even on an edge where a pop frees a slot.
    assign bus.axi_wready = (fifo_cnt < (AW+1)'(DEPTH));
    assign push           = bus.axi_wvalid && bus.axi_wready;
    assign fifo_empty     = (fifo_cnt == '0);
    // Beat slots are fixed by DRAM latency; an empty FIFO masks the beat
    // instead of stalling it.
    assign pop            = take && !fifo_empty;

    assign bus.wr_busy    = (state == WAIT) || (state == BURST);
    assign bus.wr_done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    take      = 1'b1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (len_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    take = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst) begin
            len_cnt <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_req) begin
                        len_cnt <= bus.wr_len;
                        lat_cnt <= 4'(CWL - 1);
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
                BURST: begin
                    if (len_cnt != '0) begin
                        len_cnt <= len_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage carries no reset; the cleared pointers make old contents unreachable.
    always_ff @(posedge ddr3_mcb_clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.axi_wstrb, bus.axi_wdata};
        end
    end

    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst) begin
            bus.d_wr_ld       <= 1'b0;
            bus.ddr3_mcb_wdat <= '0;
            bus.ddr3_mcb_wbe  <= '0;
            underrun          <= 1'b0;
        end else begin
            bus.d_wr_ld <= take;
            if (pop) begin
                {bus.ddr3_mcb_wbe, bus.ddr3_mcb_wdat} <= mem[rd_ptr];
            end else begin
                bus.ddr3_mcb_wbe  <= '0;
                bus.ddr3_mcb_wdat <= '0;
            end
            if (take && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
